// File: rtl/cell_ctrl_hub.sv
// Per-cell control hub: delayed call forwarding, return join with watchdog,
// and hop-routed instruction-load chain with local write or forward.
module cell_ctrl_hub #(
  parameter int NUM_RET_SRC      = 2,
  parameter int CALL_PIPE        = 1,
  parameter int INSTR_ADDR_WIDTH = 6,
  parameter int INSTR_DATA_WIDTH = 32,
  parameter int INSTR_HOPS_WIDTH = 4,
  parameter int TIMEOUT_WIDTH    = 16,
  parameter int DROP_CNT_WIDTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        call_in,
  output logic                        call_out,
  input  logic [NUM_RET_SRC-1:0]      ret_src,
  output logic                        ret_out,
  output logic                        err,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout_cfg,
  output logic                        busy,
  input  logic                        instr_en_in,
  input  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_in,
  input  logic [INSTR_DATA_WIDTH-1:0] instr_data_in,
  input  logic [INSTR_HOPS_WIDTH-1:0] instr_hops_in,
  output logic                        instr_en_out,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out,
  output logic [INSTR_DATA_WIDTH-1:0] instr_data_out,
  output logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out,
  output logic                        imem_we,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_addr,
  output logic [INSTR_DATA_WIDTH-1:0] imem_data,
  output logic [DROP_CNT_WIDTH-1:0]   drop_cnt
);

  // state | meaning
  // IDLE  | no call seen since reset
  // RUN   | call accepted, joining returns, watchdog counting
  // DONE  | all return sources seen, ret_out held high
  // ERR   | watchdog expired, err held high
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [TIMEOUT_WIDTH-1:0]    WD_ONE   = TIMEOUT_WIDTH'(1);
  localparam logic [INSTR_HOPS_WIDTH-1:0] HOPS_ONE = INSTR_HOPS_WIDTH'(1);
  localparam logic [DROP_CNT_WIDTH-1:0]   DROP_ONE = DROP_CNT_WIDTH'(1);

  state_t                   state;
  logic [NUM_RET_SRC-1:0]   ret_flags;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic [CALL_PIPE-1:0]     call_pipe;

  logic [NUM_RET_SRC-1:0] ret_all;
  logic                   join_done;
  logic                   wd_hit;
  logic                   chain_local;

  assign ret_all     = ret_flags | ret_src;
  assign join_done   = &ret_all;
  assign wd_hit      = (timeout_cfg != '0) && (wd_cnt == (timeout_cfg - WD_ONE));
  assign chain_local = (instr_hops_in == '0);
  assign call_out    = call_pipe[CALL_PIPE-1];

  // Call forwarding is a plain delay line and never looks at the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      call_pipe <= '0;
    end else begin
      call_pipe <= (call_pipe << 1) | CALL_PIPE'(call_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      ret_flags <= '0;
      wd_cnt    <= '0;
      busy      <= 1'b0;
      ret_out   <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          ret_flags <= ret_all;
          wd_cnt    <= wd_cnt + WD_ONE;
          // Completion is tested first so it beats a coincident timeout.
          if (join_done) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            ret_out <= 1'b1;
          end else if (wd_hit) begin
            state   <= S_ERR;
            busy    <= 1'b0;
            err     <= 1'b1;
            ret_out <= 1'b0;
          end
        end
        default: begin
          if (call_in) begin
            state     <= S_RUN;
            ret_flags <= '0;
            wd_cnt    <= '0;
            busy      <= 1'b1;
            ret_out   <= 1'b0;
            err       <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_en_out   <= 1'b0;
      instr_addr_out <= '0;
      instr_data_out <= '0;
      instr_hops_out <= '0;
      imem_we        <= 1'b0;
      imem_addr      <= '0;
      imem_data      <= '0;
      drop_cnt       <= '0;
    end else begin
      instr_en_out <= instr_en_in && !chain_local;
      imem_we      <= 1'b0;
      if (instr_en_in && !chain_local) begin
        instr_addr_out <= instr_addr_in;
        instr_data_out <= instr_data_in;
        instr_hops_out <= instr_hops_in - HOPS_ONE;
      end
      // A running sequencer owns the memory, so local writes are counted and dropped.
      if (instr_en_in && chain_local) begin
        if (state == S_RUN) begin
          if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_ONE;
        end else begin
          imem_we   <= 1'b1;
          imem_addr <= instr_addr_in;
          imem_data <= instr_data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_cell_ctrl_hub.sv
// Randomised and directed bench for cell_ctrl_hub against a cycle-level behavioural model.
module tb_cell_ctrl_hub;
  localparam int NRS = 3;
  localparam int CP  = 3;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int HW  = 4;
  localparam int TW  = 16;
  localparam int DCW = 8;
  localparam int DROP_MAX = (1 << DCW) - 1;

  logic clk, rst, call_in, call_out, ret_out, err, busy;
  logic [NRS-1:0] ret_src;
  logic [TW-1:0]  timeout_cfg;
  logic           instr_en_in, instr_en_out, imem_we;
  logic [AW-1:0]  instr_addr_in, instr_addr_out, imem_addr;
  logic [DW-1:0]  instr_data_in, instr_data_out, imem_data;
  logic [HW-1:0]  instr_hops_in, instr_hops_out;
  logic [DCW-1:0] drop_cnt;

  cell_ctrl_hub #(
    .NUM_RET_SRC(NRS), .CALL_PIPE(CP), .INSTR_ADDR_WIDTH(AW), .INSTR_DATA_WIDTH(DW),
    .INSTR_HOPS_WIDTH(HW), .TIMEOUT_WIDTH(TW), .DROP_CNT_WIDTH(DCW)
  ) dut (
    .clk(clk), .rst(rst), .call_in(call_in), .call_out(call_out), .ret_src(ret_src),
    .ret_out(ret_out), .err(err), .timeout_cfg(timeout_cfg), .busy(busy),
    .instr_en_in(instr_en_in), .instr_addr_in(instr_addr_in), .instr_data_in(instr_data_in),
    .instr_hops_in(instr_hops_in), .instr_en_out(instr_en_out), .instr_addr_out(instr_addr_out),
    .instr_data_out(instr_data_out), .instr_hops_out(instr_hops_out), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_data(imem_data), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 done, 3 timed out.
  int             m_mode;
  logic [NRS-1:0] m_seen;
  int             m_elapsed;
  bit             m_ret, m_err;
  bit             call_q[$];
  bit             m_call_out;
  bit             m_en_out, m_we;
  logic [AW-1:0]  m_addr_out, m_imem_addr;
  logic [DW-1:0]  m_data_out, m_imem_data;
  logic [HW-1:0]  m_hops_out;
  int             m_drop;

  task automatic model_reset();
    m_mode = 0; m_seen = '0; m_elapsed = 0; m_ret = 0; m_err = 0;
    call_q.delete();
    for (int i = 0; i < CP - 1; i++) call_q.push_back(1'b0);
    m_call_out = 0; m_en_out = 0; m_we = 0;
    m_addr_out = '0; m_data_out = '0; m_hops_out = '0;
    m_imem_addr = '0; m_imem_data = '0; m_drop = 0;
  endtask

  task automatic model_step();
    bit was_run;
    was_run = (m_mode == 1);
    call_q.push_back(call_in);
    m_call_out = call_q.pop_front();
    if (!was_run) begin
      if (call_in) begin
        m_mode = 1; m_seen = '0; m_elapsed = 0; m_err = 0; m_ret = 0;
      end
    end else begin
      m_seen = m_seen | ret_src;
      m_elapsed++;
      if (m_seen == {NRS{1'b1}}) begin
        m_mode = 2; m_ret = 1;
      end else if (timeout_cfg != 0 && m_elapsed == int'(timeout_cfg)) begin
        m_mode = 3; m_err = 1; m_ret = 0;
      end
    end
    m_en_out = instr_en_in && (instr_hops_in != 0);
    if (m_en_out) begin
      m_addr_out = instr_addr_in;
      m_data_out = instr_data_in;
      m_hops_out = instr_hops_in - 1'b1;
    end
    m_we = 0;
    if (instr_en_in && instr_hops_in == 0) begin
      if (was_run) begin
        if (m_drop < DROP_MAX) m_drop++;
      end else begin
        m_we = 1; m_imem_addr = instr_addr_in; m_imem_data = instr_data_in;
      end
    end
  endtask

  task automatic check_all();
    check("call_out", call_out, m_call_out);
    check("busy", busy, m_mode == 1);
    check("ret_out", ret_out, m_ret);
    check("err", err, m_err);
    check("instr_en_out", instr_en_out, m_en_out);
    check("instr_addr_out", instr_addr_out, m_addr_out);
    check("instr_data_out", instr_data_out, m_data_out);
    check("instr_hops_out", instr_hops_out, m_hops_out);
    check("imem_we", imem_we, m_we);
    check("imem_addr", imem_addr, m_imem_addr);
    check("imem_data", imem_data, m_imem_data);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    call_in = 0; ret_src = '0; instr_en_in = 0;
    instr_addr_in = '0; instr_data_in = '0; instr_hops_in = '0;
  endtask

  initial begin
    bit pat[8];
    pat = '{1, 0, 1, 1, 0, 0, 0, 0};
    rst = 1; timeout_cfg = '0;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    check("reset_busy", busy, 0);
    check("reset_drop", drop_cnt, 0);

    // Three-source join, pulses on bits 0/2/1 at t3/t4/t5.
    call_in = 1; tick(); call_in = 0;
    for (int t = 1; t <= 6; t++) begin
      ret_src = (t == 3) ? 3'b001 : (t == 4) ? 3'b100 : (t == 5) ? 3'b010 : 3'b000;
      tick();
      if (t == 4) check("join_busy_t5", busy, 1);
      if (t == 5) begin
        check("join_ret_t6", ret_out, 1);
        check("join_busy_t6", busy, 0);
      end
    end
    ret_src = '0;
    repeat (3) tick();
    check("join_ret_held", ret_out, 1);

    // Call delay line with back-to-back pulses; returns always present so runs finish.
    ret_src = '1;
    for (int i = 0; i < 8; i++) begin
      call_in = pat[i];
      tick();
      if (i >= 2) check("call_pipe", call_out, pat[i-2]);
      else check("call_pipe_early", call_out, 0);
    end
    call_in = 0; ret_src = '0;
    repeat (2) tick();

    // Watchdog: bit 1 never returns.
    timeout_cfg = 4;
    call_in = 1; tick(); call_in = 0;
    ret_src = 3'b101;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i == 3) check("wd_busy_t4", busy, 1);
      if (i == 4) begin
        check("wd_err_t5", err, 1);
        check("wd_ret_t5", ret_out, 0);
        check("wd_busy_t5", busy, 0);
      end
    end
    ret_src = '0;
    call_in = 1; tick(); call_in = 0;
    check("wd_err_clear", err, 0);
    check("wd_restart_busy", busy, 1);

    // Completion on the 4th RUN cycle wins over the coincident timeout.
    for (int i = 1; i <= 4; i++) begin
      ret_src = (i == 4) ? 3'b010 : 3'b101;
      tick();
    end
    check("race_ret", ret_out, 1);
    check("race_err", err, 0);
    ret_src = '0;

    // Instruction chain: forward, local write, drop while running.
    instr_en_in = 1; instr_hops_in = 2; instr_addr_in = 5; instr_data_in = 32'hDEADBEEF;
    tick();
    check("chain_fwd_en", instr_en_out, 1);
    check("chain_fwd_hops", instr_hops_out, 1);
    check("chain_fwd_data", instr_data_out, 32'hDEADBEEF);
    instr_hops_in = 0;
    tick();
    check("chain_local_we", imem_we, 1);
    check("chain_local_addr", imem_addr, 5);
    check("chain_local_noen", instr_en_out, 0);
    instr_en_in = 0;
    tick();
    check("chain_hold_hops", instr_hops_out, 1);
    timeout_cfg = 0;
    call_in = 1; tick(); call_in = 0;
    instr_en_in = 1; instr_hops_in = 0; instr_addr_in = 9;
    tick();
    check("chain_drop_we", imem_we, 0);
    check("chain_drop_cnt", drop_cnt, 1);
    for (int i = 0; i < 260; i++) begin
      instr_addr_in = AW'($urandom);
      tick();
    end
    check("drop_saturate", drop_cnt, DROP_MAX);
    instr_en_in = 0;

    // Asynchronous reset in the middle of a run with flags partly set.
    ret_src = 3'b001;
    instr_en_in = 1; instr_hops_in = 3;
    tick();
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all();
    check("async_busy", busy, 0);
    check("async_drop", drop_cnt, 0);
    @(negedge clk);
    rst = 0;
    idle_inputs();
    call_in = 1; tick(); call_in = 0;
    ret_src = 3'b010; tick();
    ret_src = 3'b100; tick();
    check("post_rst_flags_clear", busy, 1);
    ret_src = 3'b001; tick();
    check("post_rst_done", ret_out, 1);
    ret_src = '0;

    // Randomised segments with a fresh timeout per segment.
    for (int s = 0; s < 4; s++) begin
      timeout_cfg = TW'($urandom_range(0, 10));
      for (int c = 0; c < 400; c++) begin
        call_in = ($urandom_range(0, 7) == 0);
        for (int b = 0; b < NRS; b++) ret_src[b] = ($urandom_range(0, 5) == 0);
        instr_en_in   = $urandom_range(0, 1);
        instr_hops_in = HW'($urandom_range(0, 3));
        instr_addr_in = AW'($urandom);
        instr_data_in = $urandom;
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
